up_counter_en: RTL and testbench

// - Free-standing binary up-counter with synchronous count enable.
// - Used as a general event/tick counter, e.g. bit/baud position tracking in the UART datapath.
// - Provides a registered count value and a terminal-count flag for cascading or frame-end detection.

---
 rtl/up_counter_en.sv | 78 +++++++
 tb/tb_up_counter_en.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/up_counter_en.sv
// Binary up-counter with count enable, modulo MAX_COUNT+1, and a combinational terminal-count flag.
// Optional synchronous load is compiled in when UP_COUNTER_LOAD_EN is defined.
module up_counter_en #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_COUNT = (2 ** WIDTH) - 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
`ifdef UP_COUNTER_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
`endif
    output logic [WIDTH-1:0] counter_out,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_V = MAX_COUNT[WIDTH-1:0];

    logic             run_p0;
    logic             run_p1;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_next;
    logic             at_max;

    function automatic logic [WIDTH-1:0] wrap_inc(input logic [WIDTH-1:0] value);
        return (value == MAX_V) ? '0 : value + 1'b1;
    endfunction

    function automatic logic [WIDTH-1:0] fit_range(input logic [WIDTH-1:0] value);
        return (value > MAX_V) ? '0 : value;
    endfunction

    // Stage p0/p1: reset asserts at once, releases only after two clock edges
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run_p0 <= 1'b0;
            run_p1 <= 1'b0;
        end else begin
            run_p0 <= 1'b1;
            run_p1 <= run_p0;
        end
    end

    always_comb begin
        count_next = count_q;
`ifdef UP_COUNTER_LOAD_EN
        if (load) begin
            count_next = fit_range(load_value);
        end else if (enable) begin
            count_next = wrap_inc(count_q);
        end
`else
        if (enable) begin
            count_next = wrap_inc(count_q);
        end
`endif
    end

    // Count register: updates only once the synchronised reset has released
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (run_p1) begin
            count_q <= count_next;
        end
    end

    assign at_max      = (count_q == MAX_V);
    assign counter_out = count_q;

`ifdef UP_COUNTER_LOAD_EN
    assign tc = at_max && enable && !load;
`else
    assign tc = at_max && enable;
`endif

endmodule

// File: tb/tb_up_counter_en.sv
// Directed bench for up_counter_en: reset, single-step enables, wrap, modulus, async reset, load.
// Load checks are compiled in when UP_COUNTER_LOAD_EN is defined.
module tb_up_counter_en;

    logic       clock  = 1'b1;
    logic       reset  = 1'b1;
    logic       en_a   = 1'b0;
    logic       en_b   = 1'b0;
    logic [3:0] cnt_a;
    logic [3:0] cnt_b;
    logic       tc_a;
    logic       tc_b;
`ifdef UP_COUNTER_LOAD_EN
    logic       load_a = 1'b0;
    logic       load_b = 1'b0;
    logic [3:0] lval_a = 4'd0;
    logic [3:0] lval_b = 4'd0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    up_counter_en #(.WIDTH(4)) dut_a (
        .clock       (clock),
        .reset       (reset),
        .enable      (en_a),
`ifdef UP_COUNTER_LOAD_EN
        .load        (load_a),
        .load_value  (lval_a),
`endif
        .counter_out (cnt_a),
        .tc          (tc_a)
    );

    up_counter_en #(.WIDTH(4), .MAX_COUNT(9)) dut_b (
        .clock       (clock),
        .reset       (reset),
        .enable      (en_b),
`ifdef UP_COUNTER_LOAD_EN
        .load        (load_b),
        .load_value  (lval_b),
`endif
        .counter_out (cnt_b),
        .tc          (tc_b)
    );

    always @(posedge clock) begin
        if (reset) begin
            assert (!$isunknown(en_a) && !$isunknown(en_b));
        end
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1. reset pulse t=5..15 with enable low
        #5 reset = 1'b0;
        #1;
        chk("rst_cnt", 8'(cnt_a), 8'd0);
        chk("rst_tc", 8'(tc_a), 8'd0);
        chk("rst_cnt_b", 8'(cnt_b), 8'd0);
        #9 reset = 1'b1;                 // t=15
        tick();                          // edge 20: first sync flop
        chk("rel1_cnt", 8'(cnt_a), 8'd0);
        tick();                          // edge 30: second sync flop
        chk("rel2_cnt", 8'(cnt_a), 8'd0);
        chk("rel2_tc", 8'(tc_a), 8'd0);

        // 2. three single-edge enable pulses with idle cycles between
        for (int p = 1; p <= 3; p++) begin
            en_a = 1'b1;
            tick();
            en_a = 1'b0;
            chk("pulse_step", 8'(cnt_a), 8'(p));
            tick();
            chk("pulse_hold", 8'(cnt_a), 8'(p));
        end

        // return to 0 for the wrap run
        reset = 1'b0;
        #1 reset = 1'b1;
        tick();
        tick();
        chk("re_rst", 8'(cnt_a), 8'd0);

        // 3. wrap over 16 enabled edges from 0
        en_a = 1'b1;
        #1;
        chk("wrap_tc0", 8'(tc_a), 8'd0);
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("wrap_cnt", 8'(cnt_a), 8'(i % 16));
            chk("wrap_tc", 8'(tc_a), 8'((i % 16) == 15));
            if (i == 15) begin
                en_a = 1'b0;
                #1;
                chk("tc_needs_en", 8'(tc_a), 8'd0);
                en_a = 1'b1;
                #1;
            end
        end
        en_a = 1'b0;

        // 4. modulus 10 on dut_b
        en_b = 1'b1;
        #1;
        chk("mod_start", 8'(cnt_b), 8'd0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("mod_cnt", 8'(cnt_b), 8'(i % 10));
            chk("mod_tc", 8'(tc_b), 8'((i % 10) == 9));
        end
        en_b = 1'b0;

        // 5. async reset mid-count at 7
        en_a = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        chk("pre_async", 8'(cnt_a), 8'd7);
        reset = 1'b0;
        #2;
        chk("async_clr", 8'(cnt_a), 8'd0);
        chk("async_tc", 8'(tc_a), 8'd0);
        tick();
        chk("async_hold", 8'(cnt_a), 8'd0);
        reset = 1'b1;
        tick();
        chk("sync_d1", 8'(cnt_a), 8'd0);
        tick();
        chk("sync_d2", 8'(cnt_a), 8'd0);
        tick();
        chk("sync_first", 8'(cnt_a), 8'd1);

`ifdef UP_COUNTER_LOAD_EN
        // 6. load priority, tc suppression, out-of-range load
        load_a = 1'b1;
        lval_a = 4'd15;
        tick();
        chk("load_15", 8'(cnt_a), 8'd15);
        lval_a = 4'd12;
        #1;
        chk("load_tc", 8'(tc_a), 8'd0);
        tick();
        chk("load_12", 8'(cnt_a), 8'd12);
        load_a = 1'b0;
        tick();
        chk("after_load", 8'(cnt_a), 8'd13);
        load_b = 1'b1;
        lval_b = 4'd5;
        tick();
        chk("load_b5", 8'(cnt_b), 8'd5);
        lval_b = 4'd12;
        tick();
        chk("load_b_oor", 8'(cnt_b), 8'd0);
        load_b = 1'b0;
`endif
        en_a = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
